// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched: iterative DES round-key scheduler, decryption order.
// A start latches PC-1(key) into the C/D halves. K16..K1 are then emitted one per
// valid/ready handshake. The halves rotate right between rounds, so no round-key
// store is needed. After the final handshake, done_o pulses for one cycle.
//
// Optional build macro DES_KEYGEN_ENC_EN adds enc_i. When enc_i is 1 at start, the
// block emits K1..K16 using left rotations instead.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enc_i      - (DES_KEYGEN_ENC_EN only) 1 = encryption order; sampled with start_i
//   key_i      - 64-bit DES key; FIPS bit 1 is key_i[63]; parity bits are ignored
//   start_i    - load request; accepted only while busy_o is 0
//   rk_o       - current round key; FIPS bit 1 is rk_o[47]
//   rk_valid_o - rk_o is valid
//   rk_ready_i - consumer accepts rk_o
//   rk_idx_o   - round minus 1 (decrypt: key is K(16-idx); encrypt: key is K(idx+1))
//   busy_o     - schedule in progress
//   done_o     - one-cycle pulse after the 16th key is accepted
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DES_KEYGEN_ENC_EN
  input  logic        enc_i,
`endif
  input  logic [63:0] key_i,
  input  logic        start_i,
  output logic [47:0] rk_o,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [3:0]  rk_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // The tables use FIPS numbering, where bit 1 is the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-Pc1Tab[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-Pc2Tab[i]];
    return r;
  endfunction

  // DES left-rotates a half toward bit 1 (the MSB); right rotation undoes it.
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  typedef enum logic {StIdle, StEmit} state_e;

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [55:0] cd_load;
  logic        shift_two;
  logic        rot_left;
`ifdef DES_KEYGEN_ENC_EN
  logic        enc_q, enc_d;
`endif

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    cd_load   = pc1(key_i);
    shift_two = 1'b0;
    rot_left  = 1'b0;
`ifdef DES_KEYGEN_ENC_EN
    enc_d     = enc_q;
    rot_left  = enc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          c_d     = cd_load[55:28];
          d_d     = cd_load[27:0];
          cnt_d   = 4'd0;
          state_d = StEmit;
`ifdef DES_KEYGEN_ENC_EN
          enc_d = enc_i;
          // Encryption rotates before round 1, so K1 is ready immediately.
          if (enc_i) begin
            c_d = rotl(cd_load[55:28], 1'b0);
            d_d = rotl(cd_load[27:0], 1'b0);
          end
`endif
        end
      end
      StEmit: begin
        if (rk_ready_i) begin
          if (cnt_q == 4'd15) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            // Both directions rotate by one entering rounds 2, 9 and 16, and by
            // two entering every other round.
            shift_two = !(cnt_d == 4'd1 || cnt_d == 4'd8 || cnt_d == 4'd15);
            if (rot_left) begin
              c_d = rotl(c_q, shift_two);
              d_d = rotl(d_q, shift_two);
            end else begin
              c_d = rotr(c_q, shift_two);
              d_d = rotr(d_q, shift_two);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef DES_KEYGEN_ENC_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef DES_KEYGEN_ENC_EN
      enc_q   <= enc_d;
`endif
    end
  end

  assign rk_o       = pc2({c_q, d_q});
  assign rk_valid_o = (state_q == StEmit);
  assign busy_o     = (state_q == StEmit);
  assign rk_idx_o   = cnt_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
module tb_des_dec_key_sched;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_i;
  logic        start_i;
  logic [47:0] rk_o;
  logic        rk_valid_o;
  logic        rk_ready_i;
  logic [3:0]  rk_idx_o;
  logic        busy_o;
  logic        done_o;
`ifdef DES_KEYGEN_ENC_EN
  logic        enc_i;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [47:0] exp_k [16];  // exp_k[n-1] = Kn for key 133457799BBCDFF1

  des_dec_key_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DES_KEYGEN_ENC_EN
    .enc_i      (enc_i),
`endif
    .key_i      (key_i),
    .start_i    (start_i),
    .rk_o       (rk_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .rk_idx_o   (rk_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    exp_k[0]  = 48'h1B02EFFC7072;
    exp_k[1]  = 48'h79AED9DBC9E5;
    exp_k[2]  = 48'h55FC8A42CF99;
    exp_k[3]  = 48'h72ADD6DB351D;
    exp_k[4]  = 48'h7CEC07EB53A8;
    exp_k[5]  = 48'h63A53E507B2F;
    exp_k[6]  = 48'hEC84B7F618BC;
    exp_k[7]  = 48'hF78A3AC13BFB;
    exp_k[8]  = 48'hE0DBEBEDE781;
    exp_k[9]  = 48'hB1F347BA464F;
    exp_k[10] = 48'h215FD3DED386;
    exp_k[11] = 48'h7571F59467E9;
    exp_k[12] = 48'h97C5D1FABA41;
    exp_k[13] = 48'h5F43B7F2E73A;
    exp_k[14] = 48'hBF918D3D3F0A;
    exp_k[15] = 48'hCB3D8B0E17F5;

    rst_n = 1'b0; key_i = '0; start_i = 1'b0; rk_ready_i = 1'b1;
`ifdef DES_KEYGEN_ENC_EN
    enc_i = 1'b0;
`endif
    #1;
    chk("reset rk_o", rk_o, 0);
    chk("reset rk_valid_o", rk_valid_o, 0);
    chk("reset rk_idx_o", rk_idx_o, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset done_o", done_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle valid", rk_valid_o, 0);

    // Run 1: ready tied high, full schedule K16..K1.
    key_i = 64'h133457799BBCDFF1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("run1 valid %0d", i), rk_valid_o, 1);
      chk($sformatf("run1 key %0d", i), rk_o, exp_k[15-i]);
      chk($sformatf("run1 idx %0d", i), rk_idx_o, i);
      tick();
    end
    chk("run1 done", done_o, 1);
    chk("run1 busy after", busy_o, 0);
    chk("run1 valid after", rk_valid_o, 0);
    tick();
    chk("run1 done one cycle", done_o, 0);

    // Run 2: random stalls; bench-side counter sets the expected key and index.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 16; cyc++) begin
      rk_ready_i = 1'($urandom_range(0, 1));
      chk($sformatf("run2 valid c%0d", cyc), rk_valid_o, 1);
      chk($sformatf("run2 key c%0d", cyc), rk_o, exp_k[15-n]);
      chk($sformatf("run2 idx c%0d", cyc), rk_idx_o, n[3:0]);
      if (rk_ready_i) n++;
      tick();
    end
    chk("run2 handshakes", n, 16);
    chk("run2 done", done_o, 1);
    // Start in the done cycle is accepted: back-to-back schedule.
    rk_ready_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("b2b valid", rk_valid_o, 1);
    chk("b2b done cleared", done_o, 0);

    // Run 3: start with a different key mid-schedule is ignored.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("run3 key %0d", i), rk_o, exp_k[15-i]);
      chk($sformatf("run3 idx %0d", i), rk_idx_o, i);
      start_i = (i == 3);
      if (i == 3) key_i = 64'hFFFFFFFFFFFFFFFF;
      tick();
    end
    start_i = 1'b0;
    key_i = 64'h133457799BBCDFF1;
    chk("run3 done", done_o, 1);
    tick();

    // Reset mid-schedule after five handshakes.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset idx", rk_idx_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort rk_o", rk_o, 0);
    chk("abort valid", rk_valid_o, 0);
    chk("abort idx", rk_idx_o, 0);
    chk("abort busy", busy_o, 0);
    chk("abort done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-reset done", done_o, 0);
    chk("post-reset valid", rk_valid_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart key", rk_o, exp_k[15]);
    chk("restart idx", rk_idx_o, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("restart done", done_o, 1);
    tick();

    // Weak key: every round key is zero.
    key_i = 64'h0101010101010101; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("weak valid %0d", i), rk_valid_o, 1);
      chk($sformatf("weak key %0d", i), rk_o, 0);
      tick();
    end
    chk("weak done", done_o, 1);
    tick();

`ifdef DES_KEYGEN_ENC_EN
    // Encryption order K1..K16.
    key_i = 64'h133457799BBCDFF1; enc_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0; enc_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("enc key %0d", i), rk_o, exp_k[i]);
      chk($sformatf("enc idx %0d", i), rk_idx_o, i);
      tick();
    end
    chk("enc done", done_o, 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
